// File: rtl/tournament_pkg.sv
// Shared types and helpers for the tournament chooser front end.
// The queue entry is the snapshot kept for each prediction that is still in flight.
package tournament_pkg;

    localparam int unsigned HIST_W_DEF = 12;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_UP   = 2'b01,
        CNT_DOWN = 2'b10
    } cnt_dir_e;

    typedef struct packed {
        logic [HIST_W_DEF-1:0] idx;
        logic                  lp;
        logic                  gp;
        logic                  fin;
    } entry_t;

    // Up favours the global component, down favours the local one.
    function automatic cnt_dir_e counter_dir(input logic lp, input logic gp, input logic taken);
        cnt_dir_e dir;
        dir = CNT_HOLD;
        if ((gp == taken) && (lp != taken)) begin
            dir = CNT_UP;
        end else if ((lp == taken) && (gp != taken)) begin
            dir = CNT_DOWN;
        end
        return dir;
    endfunction

endpackage

// File: rtl/tup_fifo.sv
// In-order synchronous FIFO with flush; the head word is always visible on rdata_o.
// A push is taken while full if a pop happens in the same cycle.
module tup_fifo
    import tournament_pkg::*;
#(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o && !flush_i;
        do_push  = push_i && (!full_o || do_pop) && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/tournament_update_queue.sv
// Owns the speculative global history, queues issued predictions in order and
// retires them against resolved outcomes as registered chooser training updates.
module tournament_update_queue
    import tournament_pkg::*;
#(
    parameter int unsigned HIST_W = HIST_W_DEF,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              predict_valid,
    input  logic              lp_prediction,
    input  logic              gp_prediction,
    input  logic              choice_prediction,
    output logic              predict_ready,
    output logic [HIST_W-1:0] global_history,
    output logic              final_prediction,
    input  logic              resolve_valid,
    input  logic              actually_taken,
    output logic              update_valid,
    output logic [HIST_W-1:0] update_index,
    output logic              count_up,
    output logic              count_down,
    output logic              mispredict,
    output logic              underflow
);

    localparam int unsigned ENTRY_W = HIST_W + 3;

    logic [HIST_W-1:0]  hist_q, hist_d;
    logic               upd_valid_q, upd_valid_d;
    logic [HIST_W-1:0]  upd_idx_q, upd_idx_d;
    logic               cnt_up_q, cnt_up_d;
    logic               cnt_dn_q, cnt_dn_d;
    logic               misp_q, misp_d;
    logic               undf_q, undf_d;

    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic [HIST_W-1:0]  head_idx;
    logic               head_lp, head_gp, head_fin;
    logic               fifo_full, fifo_empty;
    logic               do_pop, do_push, repair;
    cnt_dir_e           dir;

    assign final_prediction = choice_prediction ? gp_prediction : lp_prediction;
    assign predict_ready    = !fifo_full;

    assign push_entry = {hist_q, lp_prediction, gp_prediction, final_prediction};
    assign head_idx   = head_entry[ENTRY_W-1:3];
    assign head_lp    = head_entry[2];
    assign head_gp    = head_entry[1];
    assign head_fin   = head_entry[0];

    // A mispredicting retire flushes everything younger, including a same-cycle issue.
    always_comb begin
        do_pop  = resolve_valid && !fifo_empty;
        repair  = do_pop && (head_fin != actually_taken);
        do_push = predict_valid && (!fifo_full || do_pop) && !repair;
        dir     = counter_dir(head_lp, head_gp, actually_taken);

        hist_d = hist_q;
        if (repair) begin
            hist_d = {head_idx[HIST_W-2:0], actually_taken};
        end else if (do_push) begin
            hist_d = {hist_q[HIST_W-2:0], final_prediction};
        end

        upd_valid_d = do_pop;
        upd_idx_d   = do_pop ? head_idx : '0;
        cnt_up_d    = do_pop && (dir == CNT_UP);
        cnt_dn_d    = do_pop && (dir == CNT_DOWN);
        misp_d      = repair;
        undf_d      = resolve_valid && fifo_empty;
    end

    tup_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .flush_i (repair),
        .push_i  (do_push),
        .pop_i   (do_pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            hist_q      <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            cnt_up_q    <= 1'b0;
            cnt_dn_q    <= 1'b0;
            misp_q      <= 1'b0;
            undf_q      <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            cnt_up_q    <= cnt_up_d;
            cnt_dn_q    <= cnt_dn_d;
            misp_q      <= misp_d;
            undf_q      <= undf_d;
        end
    end

    assign global_history = hist_q;
    assign update_valid   = upd_valid_q;
    assign update_index   = upd_idx_q;
    assign count_up       = cnt_up_q;
    assign count_down     = cnt_dn_q;
    assign mispredict     = misp_q;
    assign underflow      = undf_q;

endmodule

// File: tb/tb_tournament_update_queue.sv
// Directed and randomized checks of tournament_update_queue against a queue-based model.
module tb_tournament_update_queue;

    localparam int HW   = 12;
    localparam int D    = 8;
    localparam int MASK = (1 << HW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          predict_valid = 1'b0;
    logic          lp_prediction = 1'b0;
    logic          gp_prediction = 1'b0;
    logic          choice_prediction = 1'b0;
    logic          resolve_valid = 1'b0;
    logic          actually_taken = 1'b0;
    logic          predict_ready;
    logic [HW-1:0] global_history;
    logic          final_prediction;
    logic          update_valid;
    logic [HW-1:0] update_index;
    logic          count_up;
    logic          count_down;
    logic          mispredict;
    logic          underflow;

    always #5 clock = ~clock;

    tournament_update_queue #(
        .HIST_W (HW),
        .DEPTH  (D)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .predict_valid     (predict_valid),
        .lp_prediction     (lp_prediction),
        .gp_prediction     (gp_prediction),
        .choice_prediction (choice_prediction),
        .predict_ready     (predict_ready),
        .global_history    (global_history),
        .final_prediction  (final_prediction),
        .resolve_valid     (resolve_valid),
        .actually_taken    (actually_taken),
        .update_valid      (update_valid),
        .update_index      (update_index),
        .count_up          (count_up),
        .count_down        (count_down),
        .mispredict        (mispredict),
        .underflow         (underflow)
    );

    typedef struct {
        int idx;
        bit lp;
        bit gp;
        bit fin;
    } ment_t;

    ment_t mq[$];
    int    mhist;
    int    passed = 0;
    int    failed = 0;
    int    total  = 0;
    int    e_uv, e_idx, e_cu, e_cd, e_mp, e_uf;
    int    hsave;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outs();
        chk("global_history", 32'(global_history), mhist);
        chk("update_valid",   32'(update_valid),   e_uv);
        chk("update_index",   32'(update_index),   e_idx);
        chk("count_up",       32'(count_up),       e_cu);
        chk("count_down",     32'(count_down),     e_cd);
        chk("mispredict",     32'(mispredict),     e_mp);
        chk("underflow",      32'(underflow),      e_uf);
        chk("predict_ready",  32'(predict_ready),  32'(mq.size() < D));
    endtask

    task automatic clear_expect();
        e_uv = 0; e_idx = 0; e_cu = 0; e_cd = 0; e_mp = 0; e_uf = 0;
    endtask

    // One clock: drive inputs, advance the model by the architectural rules, compare.
    task automatic step(input bit pv, input bit lp, input bit gp, input bit ch,
                        input bit rv, input bit tk);
        ment_t e;
        bit    fin;
        predict_valid = pv; lp_prediction = lp; gp_prediction = gp;
        choice_prediction = ch; resolve_valid = rv; actually_taken = tk;
        #1;
        fin = ch ? gp : lp;
        chk("final_prediction", 32'(final_prediction), 32'(fin));
        clear_expect();
        if (rv) begin
            if (mq.size() == 0) begin
                e_uf = 1;
            end else begin
                e     = mq.pop_front();
                e_uv  = 1;
                e_idx = e.idx;
                e_cu  = int'((e.gp == tk) && (e.lp != tk));
                e_cd  = int'((e.lp == tk) && (e.gp != tk));
                e_mp  = int'(e.fin != tk);
                if (e_mp != 0) begin
                    mq.delete();
                    mhist = ((e.idx << 1) | int'(tk)) & MASK;
                end
            end
        end
        if (pv && e_mp == 0 && mq.size() < D) begin
            mq.push_back('{mhist, lp, gp, fin});
            mhist = ((mhist << 1) | int'(fin)) & MASK;
        end
        @(posedge clock);
        #1;
        check_outs();
    endtask

    task automatic issue(input bit fin);
        step(1'b1, fin, fin, 1'($urandom_range(1)), 1'b0, 1'b0);
    endtask

    task automatic resolve_ok();
        bit tk;
        tk = (mq.size() > 0) ? mq[0].fin : 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tk);
    endtask

    task automatic do_reset(input bit rv);
        reset = 1'b0;
        predict_valid = 1'b1; resolve_valid = rv;
        lp_prediction = 1'b1; gp_prediction = 1'b1; choice_prediction = 1'b0;
        @(posedge clock);
        #1;
        mq.delete();
        mhist = 0;
        clear_expect();
        check_outs();
        reset = 1'b1;
        predict_valid = 1'b0; resolve_valid = 1'b0;
    endtask

    initial begin
        bit pv, rv, tk, lp, gp, ch;
        mhist = 0;
        clear_expect();

        // reset state
        do_reset(1'b0);

        // three issues with finals 1,0,1; the first has lp=0 gp=1 choice=gp
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(1'b0);
        issue(1'b1);
        chk("hist_after_three", 32'(global_history), 32'h005);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("first_retire_index", 32'(update_index), 32'h000);
        chk("first_retire_up",    32'(count_up),     32'd1);
        resolve_ok();
        chk("second_retire_index", 32'(update_index), 32'h001);
        resolve_ok();
        chk("third_retire_index", 32'(update_index), 32'h002);

        // walk history to 0x0A3, then mispredict the oldest of four entries
        do_reset(1'b0);
        issue(1'b1); resolve_ok(); issue(1'b0); resolve_ok();
        issue(1'b1); resolve_ok(); issue(1'b0); resolve_ok();
        issue(1'b0); resolve_ok(); issue(1'b0); resolve_ok();
        issue(1'b1); resolve_ok(); issue(1'b1); resolve_ok();
        chk("hist_0a3", 32'(global_history), 32'h0A3);
        issue(1'b0); issue(1'b1); issue(1'b1); issue(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("repair_hist", 32'(global_history), 32'h147);
        chk("repair_misp", 32'(mispredict), 32'd1);
        chk("repair_index", 32'(update_index), 32'h0A3);

        // resolve on empty queue, then the pulse must drop
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("underflow_pulse", 32'(underflow), 32'd1);
        chk("underflow_hist",  32'(global_history), 32'h147);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // fill, drop one, then issue plus correct resolve while full
        for (int i = 0; i < D; i++) issue(1'($urandom_range(1)));
        chk("full_not_ready", 32'(predict_ready), 32'd0);
        hsave = int'(global_history);
        issue(1'b1);
        chk("dropped_hist", 32'(global_history), hsave);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, mq[0].fin);
        chk("full_swap_ready", 32'(predict_ready), 32'd0);

        // issue plus mispredicting resolve: issue discarded
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, !mq[0].fin);
        chk("misp_swap_ready", 32'(predict_ready), 32'd1);

        // reset with five in flight, resolve held during reset
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) issue(1'($urandom_range(1)));
        do_reset(1'b1);
        chk("reset_hist", 32'(global_history), 32'h000);
        chk("reset_no_update", 32'(update_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("reset_emptied", 32'(underflow), 32'd1);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            pv = ($urandom_range(99) < 60);
            rv = ($urandom_range(99) < 45);
            lp = 1'($urandom_range(1));
            gp = 1'($urandom_range(1));
            ch = 1'($urandom_range(1));
            if (mq.size() > 0 && $urandom_range(99) < 85) tk = mq[0].fin;
            else tk = 1'($urandom_range(1));
            step(pv, lp, gp, ch, rv, tk);
        end

        // sustained back-to-back retirement
        for (int i = 0; i < D; i++) issue(1'($urandom_range(1)));
        while (mq.size() > 0) resolve_ok();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
